// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   DataBus / DataAddrBus   data and byte-address widths
//   arb_state_e             arbiter FSM state encoding
//   SEL_*                   legal byte-lane patterns
//   cmd_t                   latched command (granted port, fields, error flag)
//   access_err()            alignment / lane-legality check applied at grant
package dmem_arbiter_pkg;

    localparam int DataBus     = 32;
    localparam int DataAddrBus = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic [3:0] SEL_B0 = 4'b0001;
    localparam logic [3:0] SEL_B1 = 4'b0010;
    localparam logic [3:0] SEL_B2 = 4'b0100;
    localparam logic [3:0] SEL_B3 = 4'b1000;
    localparam logic [3:0] SEL_H0 = 4'b0011;
    localparam logic [3:0] SEL_H1 = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;

    typedef struct packed {
        logic                   port;   // 0 = m0, 1 = m1
        logic                   we;
        logic                   err;
        logic [DataAddrBus-1:0] addr;
        logic [DataBus-1:0]     wdata;
        logic [3:0]             sel;
    } cmd_t;

    // Word accesses need addr[1:0]=0, halfword accesses need addr[0]=0,
    // single-byte lanes are always aligned; any other lane pattern
    // (including 0000) is illegal.
    function automatic logic access_err(input logic [1:0] addr_lo,
                                        input logic [3:0] sel);
        logic e;
        case (sel)
            SEL_W:                          e = (addr_lo != 2'b00);
            SEL_H0, SEL_H1:                 e = addr_lo[0];
            SEL_B0, SEL_B1, SEL_B2, SEL_B3: e = 1'b0;
            default:                        e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant selection.
// Ports:
//   req_i   [1:0]  request from m0 (bit 0) and m1 (bit 1)
//   rr_i           priority pointer: 0 favours m0, 1 favours m1
//   grant_o [1:0]  one-hot grant (all zero when nothing requests)
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       rr_i,
    output logic [1:0] grant_o
);

    // A sole requester always wins; on contention the pointer decides.
    assign grant_o[0] = req_i[0] & (~req_i[1] | ~rr_i);
    assign grant_o[1] = req_i[1] & (~req_i[0] |  rr_i);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-cycle data memory between the CPU
// MEM stage (m0) and a DMA/loader port (m1).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   m0_* / m1_*                  requester ports (req/we/addr/wdata/sel in,
//                                ack/rdata/err out)
//   stall_req                    pipeline stall = m0_req & ~m0_ack
//   mem_ce/we/addr/wdata/sel     memory command, non-zero only in ACCESS
//   mem_rdata                    combinational memory read data
//   dbg_state_o                  current FSM state, for observation
// Handshake: a requester raises req with its fields and holds them stable
// until it sees a one-cycle ack; fields are sampled only at grant. Each
// transaction takes ACCESS then RESP, so a grant in IDLE is acked two cycles
// later and back-to-back service runs at one access every two cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DataNumLog = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [DataAddrBus-1:0] m0_addr,
    input  logic [DataBus-1:0]     m0_wdata,
    input  logic [3:0]             m0_sel,
    output logic                   m0_ack,
    output logic [DataBus-1:0]     m0_rdata,
    output logic                   m0_err,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [DataAddrBus-1:0] m1_addr,
    input  logic [DataBus-1:0]     m1_wdata,
    input  logic [3:0]             m1_sel,
    output logic                   m1_ack,
    output logic [DataBus-1:0]     m1_rdata,
    output logic                   m1_err,
    output logic                   stall_req,
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [DataAddrBus-1:0] mem_addr,
    output logic [DataBus-1:0]     mem_wdata,
    output logic [3:0]             mem_sel,
    input  logic [DataBus-1:0]     mem_rdata,
    output arb_state_e             dbg_state_o
);

    // Only the low DataNumLog address bits are decoded by the memory.
    localparam logic [DataAddrBus-1:0] AddrMask =
        (DataNumLog >= DataAddrBus) ? {DataAddrBus{1'b1}}
                                    : ((32'd1 << DataNumLog) - 32'd1);

    arb_state_e         state_q;
    logic               rr_q;
    cmd_t               cmd_q;
    logic [DataBus-1:0] rsp_rdata_q;
    logic               rsp_err_q;
    logic [1:0]         ack_q;

    logic [1:0] req_mask;
    logic [1:0] arb_req;
    logic [1:0] grant;
    cmd_t       grant_cmd;
    logic       mem_go;

    // In RESP the port being acked still holds req; it must not be re-granted.
    assign req_mask = (state_q == ST_RESP) ? (cmd_q.port ? 2'b10 : 2'b01) : 2'b00;
    assign arb_req  = {m1_req, m0_req} & ~req_mask;

    rr_arb2 u_rr_arb2 (
        .req_i   (arb_req),
        .rr_i    (rr_q),
        .grant_o (grant)
    );

    always_comb begin
        grant_cmd      = '0;
        grant_cmd.port = grant[1];
        if (grant[1]) begin
            grant_cmd.we    = m1_we;
            grant_cmd.addr  = m1_addr;
            grant_cmd.wdata = m1_wdata;
            grant_cmd.sel   = m1_sel;
        end else begin
            grant_cmd.we    = m0_we;
            grant_cmd.addr  = m0_addr;
            grant_cmd.wdata = m0_wdata;
            grant_cmd.sel   = m0_sel;
        end
        grant_cmd.err = access_err(grant_cmd.addr[1:0], grant_cmd.sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 1'b0;
            cmd_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            ack_q       <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        cmd_q   <= grant_cmd;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Writes and erroring accesses return zero data.
                    rsp_rdata_q <= (cmd_q.we || cmd_q.err) ? '0 : mem_rdata;
                    rsp_err_q   <= cmd_q.err;
                    ack_q       <= cmd_q.port ? 2'b10 : 2'b01;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    rr_q <= ~cmd_q.port;
                    if (|grant) begin
                        cmd_q   <= grant_cmd;
                        state_q <= ST_ACCESS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced to zero while rst is high so an in-flight
    // transaction is aborted without an ack.
    assign m0_ack   = ack_q[0] & ~rst;
    assign m1_ack   = ack_q[1] & ~rst;
    assign m0_rdata = m0_ack ? rsp_rdata_q : '0;
    assign m1_rdata = m1_ack ? rsp_rdata_q : '0;
    assign m0_err   = m0_ack & rsp_err_q;
    assign m1_err   = m1_ack & rsp_err_q;

    assign stall_req = m0_req & ~m0_ack;

    // Erroring commands pass through ACCESS without touching memory.
    assign mem_go    = (state_q == ST_ACCESS) & ~cmd_q.err & ~rst;
    assign mem_ce    = mem_go;
    assign mem_we    = mem_go & cmd_q.we;
    assign mem_addr  = mem_go ? (cmd_q.addr & AddrMask) : '0;
    assign mem_wdata = mem_go ? cmd_q.wdata : '0;
    assign mem_sel   = mem_go ? cmd_q.sel : 4'b0000;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        stall_req, mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sel;
  arb_state_e  dbg_state;

  dmem_arbiter #(.DataNumLog(17)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .stall_req(stall_req),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_sel(mem_sel), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- external memory model ----------------
  function automatic logic [31:0] exp_word(input int w);
    logic [7:0] lo;
    lo = w[7:0];
    return {16'hC0DE, 8'h00, lo};
  endfunction

  logic        preload;
  logic [31:0] mem_model [0:255];
  assign mem_rdata = mem_model[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= (i == 4) ? 32'hDEAD_BEEF : exp_word(i);
    end else if (mem_ce && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_sel[b]) mem_model[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp0_q[$];     // {err, rdata}
  logic [32:0] exp1_q[$];
  logic [68:0] exp_mem_q[$];  // {we, addr, wdata, sel}
  int ack_port_log[$];
  int ack_cyc_log[$];
  int mem_ce_cnt = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor: pops expected responses whenever an ack appears
  always @(negedge clk) begin
    logic [32:0] e;
    logic [68:0] em;
    if (m0_ack) begin
      ack_port_log.push_back(0);
      ack_cyc_log.push_back(cyc);
      if (exp0_q.size() == 0) fail_now("m0_ack_unexpected");
      else begin
        e = exp0_q.pop_front();
        check("m0_resp", {36'd0, m0_err, m0_rdata}, {36'd0, e});
      end
    end else check("m0_noack_zero", {36'd0, m0_err, m0_rdata}, 69'd0);
    if (m1_ack) begin
      ack_port_log.push_back(1);
      ack_cyc_log.push_back(cyc);
      if (exp1_q.size() == 0) fail_now("m1_ack_unexpected");
      else begin
        e = exp1_q.pop_front();
        check("m1_resp", {36'd0, m1_err, m1_rdata}, {36'd0, e});
      end
    end else check("m1_noack_zero", {36'd0, m1_err, m1_rdata}, 69'd0);
    if (m0_ack && m1_ack) fail_now("both_acks");
    check("stall_req", {68'd0, stall_req}, {68'd0, m0_req & ~m0_ack});
    if (mem_ce) begin
      mem_ce_cnt++;
      if (exp_mem_q.size() == 0) fail_now("mem_ce_unexpected");
      else begin
        em = exp_mem_q.pop_front();
        check("mem_cmd", {mem_we, mem_addr, mem_wdata, mem_sel}, em);
      end
    end else check("mem_idle_zero", {mem_we, mem_addr, mem_wdata, mem_sel}, 69'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_sel = sel;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_sel = sel;
    end
  endtask

  // Called just after a negedge; presents the request, waits for its ack and
  // returns the number of cycles from issue to ack.
  task automatic xact(input int p, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic drop, output int lat);
    int t0;
    logic got;
    if (p == 0) exp0_q.push_back({exp_err, exp_rdata});
    else        exp1_q.push_back({exp_err, exp_rdata});
    set_port(p, 1'b1, we, addr, wdata, sel);
    t0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((p == 0) ? m0_ack : m1_ack) got = 1'b1;
    end
    lat = cyc - t0;
    if (!got) fail_now($sformatf("ack_timeout_m%0d", p));
    #1;
    if (drop || !got) set_port(p, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic single(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel,
                        input logic [31:0] exp_rdata, input logic exp_err, output int lat);
    @(negedge clk); #1;
    xact(p, we, addr, wdata, sel, exp_rdata, exp_err, 1'b1, lat);
  endtask

  task automatic seq4(input int p, input int base_word);
    int lat;
    for (int i = 0; i < 4; i++)
      xact(p, 1'b0, 32'((base_word + i) * 4), 32'd0, SEL_W, exp_word(base_word + i),
           1'b0, (i == 3), lat);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "simulation did not finish");
  end

  // ---------------- directed tests ----------------
  initial begin
    int lat, lat0, lat1, ce0;
    rst = 1'b1;
    preload = 1'b1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {67'd0, dbg_state}, {67'd0, ST_IDLE});
    check("reset_outputs", {65'd0, m0_ack, m1_ack, mem_ce, stall_req}, 69'd0);
    #1 rst = 1'b0;
    preload = 1'b0;

    // single read from m0
    ce0 = mem_ce_cnt;
    exp_mem_q.push_back({1'b0, 32'h10, 32'd0, SEL_W});
    single(0, 1'b0, 32'h10, 32'd0, SEL_W, 32'hDEAD_BEEF, 1'b0, lat);
    check("read_latency", 69'(lat), 69'd2);
    check("read_ce_pulses", 69'(mem_ce_cnt - ce0), 69'd1);

    // simultaneous write (m0) and read (m1) after reset
    do_reset();
    exp_mem_q.push_back({1'b1, 32'h20, 32'h1122_3344, SEL_W});
    exp_mem_q.push_back({1'b0, 32'h20, 32'd0, SEL_W});
    @(negedge clk); #1;
    fork
      xact(0, 1'b1, 32'h20, 32'h1122_3344, SEL_W, 32'd0, 1'b0, 1'b1, lat0);
      xact(1, 1'b0, 32'h20, 32'd0, SEL_W, 32'h1122_3344, 1'b0, 1'b1, lat1);
    join
    check("simul_m0_latency", 69'(lat0), 69'd2);
    check("simul_m1_latency", 69'(lat1), 69'd4);

    // continuous contention, 4 reads per port
    ack_port_log.delete();
    ack_cyc_log.delete();
    for (int i = 0; i < 4; i++) begin
      exp_mem_q.push_back({1'b0, 32'((32 + i) * 4), 32'd0, SEL_W});
      exp_mem_q.push_back({1'b0, 32'((40 + i) * 4), 32'd0, SEL_W});
    end
    @(negedge clk); #1;
    fork
      seq4(0, 32);
      seq4(1, 40);
    join
    check("contention_ack_count", 69'(ack_port_log.size()), 69'd8);
    for (int i = 0; i < 8 && i < ack_port_log.size(); i++) begin
      check($sformatf("contention_order_%0d", i), 69'(ack_port_log[i]), 69'(i % 2));
      if (i > 0)
        check($sformatf("contention_spacing_%0d", i),
              69'(ack_cyc_log[i] - ack_cyc_log[i-1]), 69'd2);
    end

    // misaligned word access from m1: no memory cycle, err=1, rdata=0
    ce0 = mem_ce_cnt;
    single(1, 1'b0, 32'h22, 32'd0, SEL_W, 32'd0, 1'b1, lat);
    check("misaligned_latency", 69'(lat), 69'd2);
    check("misaligned_no_ce", 69'(mem_ce_cnt - ce0), 69'd0);

    // byte write to lane 2, then read the word back
    exp_mem_q.push_back({1'b1, 32'h32, 32'h00AB_0000, SEL_B2});
    single(0, 1'b1, 32'h32, 32'h00AB_0000, SEL_B2, 32'd0, 1'b0, lat);
    exp_mem_q.push_back({1'b0, 32'h30, 32'd0, SEL_W});
    single(1, 1'b0, 32'h30, 32'd0, SEL_W, 32'hC0AB_000C, 1'b0, lat);

    // lane legality and halfword alignment
    ce0 = mem_ce_cnt;
    single(0, 1'b0, 32'h41, 32'd0, SEL_H0,  32'd0, 1'b1, lat);
    single(0, 1'b0, 32'h40, 32'd0, 4'b0101, 32'd0, 1'b1, lat);
    single(1, 1'b1, 32'h40, 32'h5555_5555, 4'b0000, 32'd0, 1'b1, lat);
    check("illegal_no_ce", 69'(mem_ce_cnt - ce0), 69'd0);
    exp_mem_q.push_back({1'b0, 32'h42, 32'd0, SEL_H1});
    single(0, 1'b0, 32'h42, 32'd0, SEL_H1, 32'hC0DE_0010, 1'b0, lat);
    exp_mem_q.push_back({1'b0, 32'h43, 32'd0, SEL_B3});
    single(1, 1'b0, 32'h43, 32'd0, SEL_B3, 32'hC0DE_0010, 1'b0, lat);

    // reset during ACCESS: aborted, then the held request is served afresh
    exp_mem_q.push_back({1'b0, 32'h10, 32'd0, SEL_W});
    @(negedge clk); #1;
    fork
      xact(0, 1'b0, 32'h10, 32'd0, SEL_W, 32'hDEAD_BEEF, 1'b0, 1'b1, lat);
      begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_access_outputs", {66'd0, m0_ack, mem_ce, mem_we}, 69'd0);
        check("rst_access_stall", {68'd0, stall_req}, 69'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_after_state", {67'd0, dbg_state}, {67'd0, ST_IDLE});
        check("rst_after_outputs", {65'd0, m0_ack, m1_ack, mem_ce, mem_we}, 69'd0);
        check("rst_after_stall", {68'd0, stall_req}, 69'd1);
      end
    join
    check("rst_retry_latency", 69'(lat), 69'd4);

    repeat (3) @(negedge clk);
    check("m0_queue_drained", 69'(exp0_q.size()), 69'd0);
    check("m1_queue_drained", 69'(exp1_q.size()), 69'd0);
    check("mem_queue_drained", 69'(exp_mem_q.size()), 69'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
